button_scan_scheduler: RTL and testbench
========================================

# button_scan_scheduler

Time-multiplexed debounce and edge-detect controller for N push buttons sharing one evaluation datapath. A shared tick divider starts a scan. During the scan an FSM visits each button once, in round-robin order, to update its debounce state. Qualified rising edges are serialized into a small event FIFO with a valid/ready interface to the menu/control logic. It replaces per-button divider/debouncer/synchronizer/edge-detector instances at the top level.

## Interface
- N_BTN, 4, number of buttons (2..8); event id width IDW = clog2(N_BTN)
- TICK_DIV, 250000, clk cycles per scan tick; must be ≥ N_BTN+2
- STABLE_TICKS, 3, consecutive differing scans needed to accept a new level (1..15)
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn  in  N_BTN  raw asynchronous button levels, 1 = pressed
- evt_valid  out  1  FIFO non-empty
- evt_id  out  IDW  button index at FIFO head (first-word-fall-through)
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- overflow  out  1  sticky: an event was dropped because FIFO full
- btn_state  out  N_BTN  debounced level per button

## Operation
- Synchronizer: two flops per btn bit in clk domain; only the second stage (sync) feeds logic.
- Tick: counter 0..TICK_DIV-1, wraps; tick = 1 for one cycle when counter == TICK_DIV-1.
- FSM states IDLE, SCAN. IDLE→SCAN on tick (j=0). SCAN: one button per cycle, k = (start + j) mod N_BTN, j = 0..N_BTN-1; after j = N_BTN-1 → IDLE and start ← (start+1) mod N_BTN.
- Per visited button k: if sync[k] == btn_state[k], cnt[k] ← 0; else if cnt[k] == STABLE_TICKS-1, btn_state[k] ← sync[k], cnt[k] ← 0, and if sync[k] == 1 raise push with id k; else cnt[k] ← cnt[k]+1. Unvisited buttons hold.
- Release (1→0) updates btn_state and generates no event.
- FIFO: pop = evt_valid & evt_ready. Push accepted if count < FIFO_DEPTH or pop in same cycle. A push while full without pop is dropped and sets overflow (held until rst). Simultaneous push+pop keeps count unchanged.
- Empty FIFO: evt_valid = 0, evt_id = 0.
- Events leave in scan-visit order; rotation of start gives each button first position once every N_BTN ticks.

## Timing
- Reset values: evt_valid 0, evt_id 0, overflow 0, btn_state 0, all cnt 0, sync flops 0, tick counter 0, start 0, FSM IDLE, FIFO empty.
- Reset mid-scan or with FIFO non-empty: next cycle is in reset state. In-flight push and queued events are discarded, and overflow is cleared.
- First tick is in the TICK_DIV-th cycle after rst deasserts. SCAN occupies the N_BTN cycles after the tick.
- The visit of button k is registered. The event is visible (evt_valid=1, evt_id=k) the cycle after its scan slot when the FIFO was empty.
- A button held steadily from t0 produces its event after STABLE_TICKS ticks whose synchronized sample is 1. With a 2-cycle synchronizer, the worst case is ≈(STABLE_TICKS+1)·TICK_DIV + N_BTN + 3 cycles.
- A glitch shorter than one tick period resets cnt at the next visit and produces no event.
- evt_ready is allowed to stay high continuously. Throughput is one pop per cycle.

## Test plan
All scenarios use N_BTN=4, TICK_DIV=8, STABLE_TICKS=3, FIFO_DEPTH=4.
- Reset/idle: rst 2 cycles with btn=0, run 100 cycles → evt_valid=0, overflow=0, btn_state=0, first tick in cycle 8.
- Single press: btn[2]=1 held, evt_ready=1 → exactly one event, evt_id=2, after the 3rd qualifying tick. btn_state[2]=1; a later release produces no event and btn_state[2]=0 after 3 ticks.
- Bounce: btn[1] toggles 1 for 6 cycles, 0 for 6, repeated 5 times, then held 1 → no event during bouncing, exactly one evt_id=1 after the hold.
- Simultaneous/fairness: btn[3:0]=1111 pressed in one cycle, evt_ready=0 → 4 events queued in rotated order. With the start index at qualification = s, the order is s, s+1, s+2, s+3 mod 4. overflow=0.
- Overflow: evt_ready=0, fill 4 events, release all, press btn[0] again → 5th event dropped, overflow=1 and held. Draining gives the original 4 ids in order.
- Reset mid-operation: assert rst during SCAN with 2 events queued → next cycle evt_valid=0, overflow=0, btn_state=0. A held button re-qualifies after 3 ticks.

Source files
------------

// File: rtl/button_scan_scheduler.sv
// Time-multiplexed debounce and rising-edge detector for N_BTN buttons.
// One shared datapath visits each button once per scan tick; presses are queued in a FWFT FIFO.
module button_scan_scheduler #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 3,
  parameter int FIFO_DEPTH   = 4,
  localparam int IDW         = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  input  logic             evt_ready,
  output logic             overflow,
  output logic [N_BTN-1:0] btn_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [IDW-1:0] J_LAST     = IDW'(N_BTN - 1);
  localparam logic [IDW:0]   N_WRAP     = (IDW + 1)'(N_BTN);
  localparam logic [3:0]     CNT_LAST   = 4'(STABLE_TICKS - 1);
  localparam logic [PW:0]    DEPTH_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [0:0]     IDLE       = 1'b0;
  localparam logic [0:0]     SCAN       = 1'b1;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    logic [IDW:0] sum;
    logic [IDW:0] diff;
    sum  = {1'b0, a} + {1'b0, b};
    diff = sum - N_WRAP;
    return (sum >= N_WRAP) ? diff[IDW-1:0] : sum[IDW-1:0];
  endfunction

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync_r;
  logic [TW-1:0]    tick_cnt_r;
  logic             tick_s;
  logic [0:0]       state_r;
  logic [IDW-1:0]   j_r;
  logic [IDW-1:0]   start_r;
  logic [IDW-1:0]   k_s;
  logic             scan_s;
  logic [3:0]       cnt_r [N_BTN];
  logic [N_BTN-1:0] btn_state_r;
  logic             vis_sync_s;
  logic             vis_state_s;
  logic [3:0]       vis_cnt_s;
  logic [3:0]       cnt_nxt_s;
  logic             state_nxt_s;
  logic             push_s;

  logic [IDW-1:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    rd_inc_s;
  logic [PW-1:0]    rd_nxt_s;
  logic [PW:0]      count_r;
  logic [PW:0]      count_nxt_s;
  logic             pop_s;
  logic             full_s;
  logic             push_acc_s;
  logic             drop_s;
  logic [IDW-1:0]   head_nxt_s;
  logic             evt_valid_r;
  logic [IDW-1:0]   evt_id_r;
  logic             overflow_r;

  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Debounce decision for the button visited in the current scan slot
  always_comb begin
    k_s         = wrap_add(start_r, j_r);
    scan_s      = (state_r == SCAN);
    vis_sync_s  = sync_r[k_s];
    vis_state_s = btn_state_r[k_s];
    vis_cnt_s   = cnt_r[k_s];
    cnt_nxt_s   = 4'd0;
    state_nxt_s = vis_state_s;
    push_s      = 1'b0;
    if (vis_sync_s == vis_state_s) begin
      cnt_nxt_s = 4'd0;
    end else if (vis_cnt_s == CNT_LAST) begin
      cnt_nxt_s   = 4'd0;
      state_nxt_s = vis_sync_s;
      push_s      = scan_s & vis_sync_s;
    end else begin
      cnt_nxt_s = vis_cnt_s + 4'd1;
    end
  end

  // FIFO control and next head; a push into an empty queue becomes the head directly
  always_comb begin
    pop_s      = evt_valid_r & evt_ready;
    full_s     = (count_r == DEPTH_FULL);
    push_acc_s = push_s & (~full_s | pop_s);
    drop_s     = push_s & full_s & ~pop_s;
    rd_inc_s   = rd_ptr_r + PW'(1);
    rd_nxt_s   = pop_s ? rd_inc_s : rd_ptr_r;
    case ({push_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + (PW + 1)'(1);
      2'b01:   count_nxt_s = count_r - (PW + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == {(PW + 1){1'b0}}) begin
      head_nxt_s = {IDW{1'b0}};
    end else if (pop_s) begin
      head_nxt_s = (count_r == (PW + 1)'(1)) ? k_s : mem_r[rd_inc_s];
    end else begin
      head_nxt_s = (count_r == {(PW + 1){1'b0}}) ? k_s : mem_r[rd_ptr_r];
    end
  end

  // Input synchronizer, scan tick divider and round-robin scan FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= {N_BTN{1'b0}};
      sync_r     <= {N_BTN{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
      state_r    <= IDLE;
      j_r        <= {IDW{1'b0}};
      start_r    <= {IDW{1'b0}};
    end else begin
      sync1_r    <= btn;
      sync_r     <= sync1_r;
      tick_cnt_r <= tick_s ? {TW{1'b0}} : tick_cnt_r + TW'(1);
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r <= SCAN;
            j_r     <= {IDW{1'b0}};
          end
        end
        SCAN: begin
          if (j_r == J_LAST) begin
            state_r <= IDLE;
            start_r <= wrap_add(start_r, IDW'(1));
          end else begin
            j_r <= j_r + IDW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          j_r     <= {IDW{1'b0}};
        end
      endcase
    end
  end

  // Per-button debounce counters and debounced levels; only the visited button moves
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= 4'd0;
      end
      btn_state_r <= {N_BTN{1'b0}};
    end else if (scan_s) begin
      cnt_r[k_s]       <= cnt_nxt_s;
      btn_state_r[k_s] <= state_nxt_s;
    end
  end

  // Event FIFO storage with registered valid/head and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {IDW{1'b0}};
      end
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {(PW + 1){1'b0}};
      evt_valid_r <= 1'b0;
      evt_id_r    <= {IDW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      if (push_acc_s) begin
        mem_r[wr_ptr_r] <= k_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      evt_valid_r <= (count_nxt_s != {(PW + 1){1'b0}});
      evt_id_r    <= head_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_id    = evt_id_r;
  assign overflow  = overflow_r;
  assign btn_state = btn_state_r;

endmodule

// File: tb/tb_button_scan_scheduler.sv
// Directed bench for button_scan_scheduler with N_BTN=4, TICK_DIV=8, STABLE_TICKS=3, FIFO_DEPTH=4.
// Cycle numbers below count from 1 = first cycle after reset is released.
module tb_button_scan_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic       overflow;
  logic [3:0] btn_state;

  int   n_checks;
  int   n_pass;
  logic seen;
  logic b1;

  button_scan_scheduler #(
    .N_BTN(4),
    .TICK_DIV(8),
    .STABLE_TICKS(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .overflow(overflow),
    .btn_state(btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    btn       = 4'b0000;
    evt_ready = 1'b0;

    // Reset / idle
    do_reset();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(btn_state), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      seen = seen | evt_valid | overflow | (|btn_state);
      step(1);
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // Single press on button 2, qualifies in scan 3 slot at cycle 25
    do_reset();
    evt_ready = 1'b1;
    btn = 4'b0100;
    step(24);
    check("press_pre_valid", 32'(evt_valid), 32'd0);
    check("press_pre_state", 32'(btn_state), 32'd0);
    step(1);
    check("press_valid", 32'(evt_valid), 32'd1);
    check("press_id", 32'(evt_id), 32'd2);
    check("press_state", 32'(btn_state), 32'h4);
    step(1);
    check("press_popped", 32'(evt_valid), 32'd0);
    btn = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 23; i++) begin
      seen = seen | evt_valid;
      step(1);
    end
    check("release_pre_state", 32'(btn_state), 32'h4);
    step(1);
    check("release_state", 32'(btn_state), 32'h0);
    for (int i = 0; i < 10; i++) begin
      seen = seen | evt_valid;
      step(1);
    end
    check("release_no_evt", 32'(seen), 32'd0);

    // Bounce on button 1 (6 high / 6 low x5), then held from cycle 61
    do_reset();
    evt_ready = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 81; c++) begin
      seen = seen | evt_valid;
      b1 = (c > 60) ? 1'b1 : ((((c - 1) / 6) % 2) == 0);
      btn = {2'b00, b1, 1'b0};
      step(1);
    end
    check("bounce_no_evt", 32'(seen), 32'd0);
    check("bounce_valid", 32'(evt_valid), 32'd1);
    check("bounce_id", 32'(evt_id), 32'd1);
    step(1);
    check("bounce_single", 32'(evt_valid), 32'd0);

    // All four pressed together; qualification scan has start = 2
    do_reset();
    evt_ready = 1'b0;
    btn = 4'b1111;
    step(24);
    check("fair_pre_valid", 32'(evt_valid), 32'd0);
    step(1);
    check("fair_valid", 32'(evt_valid), 32'd1);
    check("fair_id0", 32'(evt_id), 32'd2);
    step(4);
    check("fair_state", 32'(btn_state), 32'hf);
    check("fair_ovf", 32'(overflow), 32'd0);
    check("fair_hold_id", 32'(evt_id), 32'd2);
    evt_ready = 1'b1;
    step(1);
    check("fair_id1", 32'(evt_id), 32'd3);
    step(1);
    check("fair_id2", 32'(evt_id), 32'd0);
    step(1);
    check("fair_id3", 32'(evt_id), 32'd1);
    check("fair_valid3", 32'(evt_valid), 32'd1);
    step(1);
    check("fair_empty_valid", 32'(evt_valid), 32'd0);
    check("fair_empty_id", 32'(evt_id), 32'd0);

    // Overflow: fill 4, release all, press button 0 again
    do_reset();
    evt_ready = 1'b0;
    btn = 4'b1111;
    step(28);
    btn = 4'b0000;
    step(24);
    check("ovf_released", 32'(btn_state), 32'h0);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    btn = 4'b0001;
    step(20);
    check("ovf_before_drop", 32'(overflow), 32'd0);
    step(1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_state", 32'(btn_state), 32'h1);
    check("ovf_head", 32'(evt_id), 32'd2);
    step(6);
    check("ovf_held", 32'(overflow), 32'd1);
    evt_ready = 1'b1;
    check("drain_id0", 32'(evt_id), 32'd2);
    step(1);
    check("drain_id1", 32'(evt_id), 32'd3);
    step(1);
    check("drain_id2", 32'(evt_id), 32'd0);
    check("drain_ovf", 32'(overflow), 32'd1);

    // Reset during scan (cycle 82) with two events queued and overflow set
    evt_ready = 1'b0;
    rst = 1'b1;
    step(1);
    check("midrst_valid", 32'(evt_valid), 32'd0);
    check("midrst_id", 32'(evt_id), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_state", 32'(btn_state), 32'd0);
    rst = 1'b0;
    step(26);
    check("requal_pre", 32'(evt_valid), 32'd0);
    step(1);
    check("requal_valid", 32'(evt_valid), 32'd1);
    check("requal_id", 32'(evt_id), 32'd0);
    check("requal_state", 32'(btn_state), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
